rxadc_capbuf: RTL and testbench
===============================

// Module: rxadc_capbuf
// PURPOSE
//  Parametrised multi-channel ADC sample capture buffer; successor to the single-channel rxadc capture path.
//  Sits between the rxadc front end (or DDC outputs) and the SPI register slave. A trigger from the
//  register file starts a capture of a programmed number of samples into block RAM. The MCU reads the
//  samples back over SPI by word address and channel select.
// PARAMETERS
//  DW   10  sample width per channel (bits)
//  AW   10  log2 buffer depth; DEPTH = 2**AW samples per channel
//  NCH  2   number of channels captured in parallel (1..4)
// PORTS
//  clk      in   1         system clock; all logic is clocked on its rising edge
//  reset    in   1         synchronous, active-high reset
//  ena      in   1         sample strobe; din/otr are valid when ena=1
//  din      in   NCH*DW    channel samples, ch0 in [DW-1:0]
//  otr      in   NCH       per-channel out-of-range flags, stored with each sample
//  trig     in   1         capture start; level is sampled every clk, and the rising edge is used
//  cnt      in   AW+1      samples to capture; 0 or >DEPTH means DEPTH
//  pre      in   AW        pre-trigger samples (used only with RXADC_CAPBUF_PRETRIG_EN)
//  rd_ch    in   2         readback channel select; values >= NCH return 0
//  rd_addr  in   AW        readback sample index relative to the start of the capture
//  rd_data  out  DW+1      {otr, sample}; registered
//  active   out  1         capture in progress
//  done     out  1         capture complete; held until the next capture starts
//  wcount   out  AW+1      samples written in the current or last capture
// BEHAVIOUR
//  Reset: state=IDLE; active=0; done=0; wcount=0; rd_data=0; wptr=0; start address sa=0. RAM contents are not cleared.
//  Trigger: trig_re = trig & ~trig_d (trig_d is a register). A held trig level gives only one start.
//  States:
//   IDLE -> CAP on trig_re. On entry: wcount=0, done=0, active=1, sa=wptr, target n=eff(cnt).
//   CAP: on each ena, write all NCH channels at wptr; wptr=wptr+1 (mod DEPTH); wcount+1.
//        When the write that makes wcount==n occurs, go to DONE on the next edge: active=0, done=1.
//        trig_re while in CAP is ignored.
//   DONE -> CAP on trig_re, with the same entry actions as from IDLE. Otherwise hold.
//  eff(cnt) = (cnt==0 || cnt>DEPTH) ? DEPTH : cnt.
//  RAM: one word per index, NCH*(DW+1) bits wide. Write and read are in the same clk domain.
//   rd_data = word[(sa+rd_addr) mod DEPTH] for channel rd_ch, registered. Latency 2 clk from rd_addr
//   (RAM read + output register).
//  wptr wraps modulo DEPTH. A capture may start anywhere and wraps transparently; rd_addr is always relative to sa.
//  Simultaneous ena and trig_re in IDLE/DONE: that ena sample is NOT captured. Capture starts with the next ena.
//  Reset during CAP aborts the capture: state=IDLE, done=0, active=0, wcount=0.
//  Reads during CAP are allowed and return data current at read time. No read/write collision protection.
//  cnt and pre are sampled only at trig_re; changing them mid-capture has no effect.
// CONFIGURATION
//  RXADC_CAPBUF_PRETRIG_EN defined:
//   - In IDLE/DONE, RAM is written continuously on every ena (circular); a fill counter saturates at DEPTH.
//   - On trig_re: p = min(pre, n-1, fill); sa = wptr-p (mod DEPTH); wcount starts at p.
//     The capture then continues until wcount==n, so rd_addr 0..p-1 are pre-trigger samples.
//   - fill resets to 0 on reset only.
//  RXADC_CAPBUF_PRETRIG_EN undefined:
//   - pre is ignored and RAM is written only in CAP.
//   - The pre input port still exists and is unused.
// TESTING
//  T1 NCH=2, cnt=16, ramp din (ch0=k, ch1=1000-k, k counts ena), trig pulse
//     -> active for exactly 16 ena; then done=1, wcount=16; rd_ch=1, rd_addr=3 -> 997-k0 (k0 = first captured k).
//  T2 cnt=0 and cnt=DEPTH+5, ena every 3rd clk
//     -> both capture DEPTH samples; done after DEPTH ena; back-to-back retrigger from DONE re-clears done.
//  T3 trig held high for 50 clk, with ena and trig_re coinciding
//     -> one capture only; the coincident sample is absent; readback index 0 = next sample.
//  T4 start with wptr=DEPTH-4, cnt=8
//     -> wptr wraps; rd_addr 0..7 read 8 consecutive ramp values with no discontinuity.
//  T5 reset asserted at wcount=5 during CAP
//     -> next clk: active=0, done=0, wcount=0; a later trig captures normally.
//  T6 (PRETRIG_EN) pre=4, cnt=10, ramp running 20 ena before trig
//     -> wcount starts at 4; rd_addr 0..3 = the 4 samples preceding trig; done after 6 more ena;
//        pre=12, cnt=10 -> p=9.

Source files
------------

// File: rtl/rxadc_capbuf_if.sv
// Capture buffer bus: sample input, capture control, status and readback.
// The master side (front end / register file) drives samples, trigger and
// read address; the slave side (rxadc_capbuf) returns status and read data.
interface rxadc_capbuf_if #(
    parameter int DW  = 10,
    parameter int AW  = 10,
    parameter int NCH = 2
);
    logic              ena;
    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    otr;
    logic              trig;
    logic [AW:0]       cnt;
    logic [AW-1:0]     pre;
    logic [1:0]        rd_ch;
    logic [AW-1:0]     rd_addr;
    logic [DW:0]       rd_data;
    logic              active;
    logic              done;
    logic [AW:0]       wcount;

    modport master (
        output ena, din, otr, trig, cnt, pre, rd_ch, rd_addr,
        input  rd_data, active, done, wcount
    );

    modport slave (
        input  ena, din, otr, trig, cnt, pre, rd_ch, rd_addr,
        output rd_data, active, done, wcount
    );
endinterface

// File: rtl/rxadc_capbuf.sv
// rxadc_capbuf: multi-channel ADC sample capture buffer with SPI-style readback.
// Optional pre-trigger capture (continuous circular writing while idle) is
// enabled by defining RXADC_CAPBUF_PRETRIG_EN; the default build captures
// only after the trigger and leaves the pre input unused.
//
//  state  | meaning
//  S_IDLE | no capture since reset; waiting for a trigger rising edge
//  S_CAP  | capture running; every ena writes one sample per channel
//  S_DONE | programmed count reached; data held for readback until retrigger
module rxadc_capbuf #(
    parameter int DW  = 10,
    parameter int AW  = 10,
    parameter int NCH = 2
) (
    input logic           clk,
    input logic           reset,
    rxadc_capbuf_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int WW    = NCH * (DW + 1);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAP, S_DONE} state_t;

    state_t         state, state_nxt;
    logic           active_c, done_c;
    logic           trig_d, trig_re, start, wr_en;
    logic [AW-1:0]  wptr, sa, rd_idx;
    logic [AW:0]    n, wcount, n_eff, p_sel;
    logic [WW-1:0]  mem [DEPTH];
    logic [WW-1:0]  wr_word, rd_word;
    logic [1:0]     rd_ch_q;
    logic [DW:0]    rd_sel, rd_data;

    assign trig_re = bus.trig & ~trig_d;
    assign start   = trig_re & (state != S_CAP);
    assign n_eff   = (bus.cnt == '0 || bus.cnt > DEPTH_C) ? DEPTH_C : bus.cnt;
    assign rd_idx  = sa + bus.rd_addr;

`ifdef RXADC_CAPBUF_PRETRIG_EN
    logic [AW:0] fill;

    // While idle the RAM runs as a circular history; the sample coinciding
    // with the trigger edge is dropped so that index p is the first post-trigger sample.
    assign wr_en = bus.ena & ((state == S_CAP) | ~trig_re);

    // Pre-trigger depth: requested count, keeping at least one post-trigger
    // sample and never reaching back past what the RAM actually holds.
    always_comb begin
        p_sel = {1'b0, bus.pre};
        if (n_eff - 1'b1 < p_sel) p_sel = n_eff - 1'b1;
        if (fill < p_sel) p_sel = fill;
    end

    // Number of valid samples in the circular history, saturating at full depth.
    always_ff @(posedge clk) begin
        if (reset) fill <= '0;
        else if (wr_en && fill != DEPTH_C) fill <= fill + 1'b1;
    end
`else
    assign wr_en = bus.ena & (state == S_CAP);
    assign p_sel = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and status outputs; the final write moves straight to S_DONE.
    always_comb begin
        state_nxt = state;
        active_c  = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: if (trig_re) state_nxt = S_CAP;
            S_CAP: begin
                active_c = 1'b1;
                if (bus.ena && (wcount + 1'b1 == n)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_c = 1'b1;
                if (trig_re) state_nxt = S_CAP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Trigger edge detect, capture window latching, write pointer and sample count.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_d <= 1'b0;
            wptr   <= '0;
            sa     <= '0;
            n      <= '0;
            wcount <= '0;
        end else begin
            trig_d <= bus.trig;
            if (start) begin
                sa     <= wptr - p_sel[AW-1:0];
                n      <= n_eff;
                wcount <= p_sel;
            end else if (state == S_CAP && bus.ena) begin
                wcount <= wcount + 1'b1;
            end
            if (wr_en) wptr <= wptr + 1'b1;
        end
    end

    // Pack all channels with their out-of-range flags into one RAM word.
    always_comb begin
        wr_word = '0;
        for (int c = 0; c < NCH; c++) begin
            wr_word[c*(DW+1) +: DW+1] = {bus.otr[c], bus.din[c*DW +: DW]};
        end
    end

    // Block RAM: no reset so it maps onto memory primitives.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_word;
        rd_word <= mem[rd_idx];
    end

    // Channel select on the RAM output; unused channel codes read as zero.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ch_q == 2'(c)) rd_sel = rd_word[c*(DW+1) +: DW+1];
        end
    end

    // Output register; the channel select is delayed to line up with the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ch_q <= '0;
            rd_data <= '0;
        end else begin
            rd_ch_q <= bus.rd_ch;
            rd_data <= rd_sel;
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.active  = active_c;
    assign bus.done    = done_c;
    assign bus.wcount  = wcount;
endmodule

// File: tb/tb_rxadc_capbuf.sv
// Bench for rxadc_capbuf: random ena patterns on a ramp, scoreboard of
// expected status per cycle and expected readback words.
module tb_rxadc_capbuf;
    localparam int DW    = 10;
    localparam int AW    = 5;
    localparam int NCH   = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rxadc_capbuf_if #(.DW(DW), .AW(AW), .NCH(NCH)) bus ();

    rxadc_capbuf #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NCH-1:0][DW-1:0] d;
        logic [NCH-1:0]         o;
    } smp_t;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t stq[$];
    exp_t rdq[$];

    // reference model state
    bit   m_cap, m_done, m_trig_d;
    int   m_n, m_wc, m_fill, m_wr, m_cnt, m_pre;
    smp_t cap_q[$];
    smp_t hist[$];

    int k = 0;
    int cyc_n = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int due);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, due, act, exp);
        end
    endtask

    function automatic void m_write(smp_t s);
        hist.push_back(s);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (m_fill < DEPTH) m_fill++;
        m_wr++;
    endfunction

    // Behaviour of one clock edge given the inputs presented before it.
    function automatic void model(bit rst, bit e, bit t, smp_t s);
        bit re;
        int p;
        if (rst) begin
            m_cap = 0; m_done = 0; m_wc = 0; m_trig_d = 0;
            m_fill = 0; m_wr = 0;
            hist.delete();
            cap_q.delete();
            return;
        end
        re = t && !m_trig_d;
        m_trig_d = t;
        if (!m_cap && re) begin
            m_n = (m_cnt == 0 || m_cnt > DEPTH) ? DEPTH : m_cnt;
            p = 0;
`ifdef RXADC_CAPBUF_PRETRIG_EN
            p = m_pre;
            if (p > m_n - 1) p = m_n - 1;
            if (p > m_fill) p = m_fill;
`endif
            cap_q.delete();
            for (int i = hist.size() - p; i < hist.size(); i++) cap_q.push_back(hist[i]);
            m_wc = p;
            m_cap = 1;
            m_done = 0;
        end else if (m_cap && e) begin
            cap_q.push_back(s);
            m_write(s);
            m_wc++;
            if (m_wc == m_n) begin
                m_cap = 0;
                m_done = 1;
            end
        end else if (!m_cap && e) begin
`ifdef RXADC_CAPBUF_PRETRIG_EN
            m_write(s);
`endif
        end
    endfunction

    task automatic tick(input bit rst, input bit e, input bit t);
        smp_t  s;
        exp_t  x;
        s.d[0] = k[DW-1:0];
        s.d[1] = DW'(1000 - k);
        s.o    = NCH'($urandom);
        reset    = rst;
        bus.ena  = e;
        bus.trig = t;
        bus.din  = s.d;
        bus.otr  = s.o;
        @(posedge clk);
        cyc_n++;
        model(rst, e, t, s);
        if (e) k++;
        x.due = cyc_n;
        x.sel = 0; x.exp = 32'(m_cap);  stq.push_back(x);
        x.sel = 1; x.exp = 32'(m_done); stq.push_back(x);
        x.sel = 2; x.exp = 32'(m_wc);   stq.push_back(x);
        if (rst) begin
            x.sel = 3; x.exp = '0; rdq.push_back(x);
        end
        #1;
    endtask

    function automatic bit ena_pick(int mode);
        if (mode == 1) return (cyc_n % 3) == 2;
        if (mode == 2) return 1'b1;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic capture(input int cnt, input int mode, input bit e_on_trig, input bit mid_trig);
        m_cnt   = cnt;
        bus.cnt = (AW + 1)'(cnt);
        m_pre   = m_pre;
        tick(0, e_on_trig, 1);
        for (int i = 0; i < 20 * DEPTH && m_cap; i++) tick(0, ena_pick(mode), mid_trig && i == 3);
        if (m_cap) begin
            n_chk++; n_fail++;
            $display("FAIL capture_budget: capture of %0d not finished, wcount model %0d", cnt, m_wc);
        end
    endtask

    task automatic rd(input int ch, input int a);
        exp_t x;
        smp_t sm;
        bus.rd_ch   = 2'(ch);
        bus.rd_addr = AW'(a);
        tick(0, 1'b0, 1'b0);
        x.due = cyc_n + 1;
        x.sel = 3;
        if (ch >= NCH) begin
            x.exp = '0;
            rdq.push_back(x);
        end else if (a < cap_q.size()) begin
            sm = cap_q[a];
            x.exp = 32'({sm.o[ch], sm.d[ch]});
            rdq.push_back(x);
        end
    endtask

    task automatic readback(input int n);
        for (int a = 0; a < n; a++) begin
            rd(0, a);
            rd(1, a);
        end
        rd(2 + int'($urandom_range(0, 1)), $urandom_range(0, n - 1));
    endtask

    // Scoreboard monitor: compares everything due by this cycle, mid-period.
    always @(negedge clk) begin
        exp_t x;
        while (stq.size() > 0 && stq[0].due <= cyc_n) begin
            x = stq.pop_front();
            case (x.sel)
                0:       check("active", 32'(bus.active), x.exp, x.due);
                1:       check("done", 32'(bus.done), x.exp, x.due);
                default: check("wcount", 32'(bus.wcount), x.exp, x.due);
            endcase
        end
        while (rdq.size() > 0 && rdq[0].due <= cyc_n) begin
            x = rdq.pop_front();
            check("rd_data", 32'(bus.rd_data), x.exp, x.due);
        end
    end

    initial begin
        int w;
        bus.ena = 0; bus.din = '0; bus.otr = '0; bus.trig = 0;
        bus.cnt = '0; bus.pre = '0; bus.rd_ch = '0; bus.rd_addr = '0;
        m_cnt = 0; m_pre = 0;

        repeat (3) tick(1, 0, 0);
        repeat (4) tick(0, ena_pick(0), 0);

        // T1: 16-sample capture with a retrigger attempt during capture
        m_pre = $urandom_range(0, DEPTH - 1);
        bus.pre = AW'(m_pre);
`ifdef RXADC_CAPBUF_PRETRIG_EN
        m_pre = 0; bus.pre = '0;
`endif
        capture(16, 0, 0, 1);
        repeat (3) tick(0, ena_pick(0), 0);
        readback(16);

        // T2: cnt=0 and cnt>DEPTH both mean DEPTH; second one retriggers from DONE
        capture(0, 1, 0, 0);
        capture(DEPTH + 5, 1, 1, 0);
        readback(DEPTH);

        // T3: trig held high with a coincident ena on the rising edge
        m_cnt = 8; bus.cnt = (AW + 1)'(8);
        tick(0, 1, 1);
        for (int i = 0; i < 49; i++) tick(0, ena_pick(0), 1);
        for (int i = 0; i < 20 * DEPTH && m_cap; i++) tick(0, ena_pick(0), 0);
        tick(0, 0, 0);
        readback(8);

        // T4: align the write pointer to DEPTH-4, then capture across the wrap
        w = ((DEPTH - 4) - (m_wr % DEPTH) + DEPTH) % DEPTH;
        if (w != 0) capture(w, 2, 0, 0);
        capture(8, 0, 0, 0);
        readback(8);

        // T5: reset in the middle of a capture, then a normal capture
        m_cnt = 16; bus.cnt = (AW + 1)'(16);
        tick(0, 0, 1);
        for (int i = 0; i < 200 && m_wc < 5; i++) tick(0, ena_pick(0), 0);
        tick(1, 1, 0);
        repeat (3) tick(0, ena_pick(0), 0);
        capture(6, 0, 0, 0);
        readback(6);

`ifdef RXADC_CAPBUF_PRETRIG_EN
        // T6: pre-trigger history
        tick(1, 0, 0);
        m_pre = 4; bus.pre = AW'(4);
        repeat (20) tick(0, 1, 0);
        capture(10, 0, 0, 0);
        readback(10);
        m_pre = 12; bus.pre = AW'(12);
        repeat (5) tick(0, 1, 0);
        capture(10, 0, 0, 0);
        readback(10);
`endif

        repeat (4) tick(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
